// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared widths and state encoding for the memory access sequencer
package mem_ctrl_pkg;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam int CNT_W = 4;
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADDR     = 3'd1,
    S_RD_WAIT  = 3'd2,
    S_RD_LATCH = 3'd3,
    S_ST_DATA  = 3'd4,
    S_WR_WAIT  = 3'd5,
    S_DONE     = 3'd6,
    S_ERR      = 3'd7
  } state_t;
endpackage

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences MAR/MDR/RAM strobes for single load/store requests
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W = mem_ctrl_pkg::ADDR_W
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     start_load,
  input  logic                     start_store,
  input  logic [DATA_W-ADDR_W-1:0] bus_addr_hi,
  output logic                     MAR_enable,
  output logic                     MDR_enable,
  output logic                     read,
  output logic                     write,
  output logic                     MDR_out,
  output logic                     busy,
  output logic                     done,
  output logic                     addr_err
);
  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("WAIT_CYCLES must be in 1..15");
  end
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic ld_q, ld_d;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    ld_d = ld_q;
    case (state_q)
      S_IDLE: if (start_load || start_store) begin
        ld_d = start_load;
        state_d = |bus_addr_hi ? S_ERR : S_ADDR;
      end
      S_ADDR: begin
        cnt_d = CNT_LOAD;
        state_d = ld_q ? S_RD_WAIT : S_ST_DATA;
      end
      S_RD_WAIT: if (cnt_q == '0) state_d = S_RD_LATCH; else cnt_d = cnt_q - 1'b1;
      S_RD_LATCH: state_d = S_DONE;
      S_ST_DATA: state_d = S_WR_WAIT;
      S_WR_WAIT: if (cnt_q == '0) state_d = S_DONE; else cnt_d = cnt_q - 1'b1;
      default: state_d = S_IDLE;
    endcase
  end
  // outputs decode the next state so they line up with the registered state
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      ld_q <= 1'b0;
      MAR_enable <= 1'b0;
      MDR_enable <= 1'b0;
      read <= 1'b0;
      write <= 1'b0;
      MDR_out <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ld_q <= ld_d;
      MAR_enable <= state_d == S_ADDR;
      MDR_enable <= state_d == S_RD_LATCH || state_d == S_ST_DATA;
      read <= state_d == S_RD_WAIT || state_d == S_RD_LATCH;
      write <= state_d == S_WR_WAIT;
      MDR_out <= state_d == S_DONE && ld_d;
      busy <= state_d != S_IDLE;
      done <= state_d == S_DONE;
      addr_err <= state_d == S_ERR;
    end
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed vector table plus corner sequences for WAIT_CYCLES 1 and 3
module tb_mem_access_ctrl;
  logic clk = 1'b0;
  logic clr = 1'b1;
  logic start_load = 1'b0;
  logic start_store = 1'b0;
  logic [22:0] bus_addr_hi = '0;
  wire [7:0] o1, o3;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  mem_access_ctrl #(.WAIT_CYCLES(1)) u1 (
    .clk(clk), .clr(clr), .start_load(start_load), .start_store(start_store),
    .bus_addr_hi(bus_addr_hi), .MAR_enable(o1[7]), .MDR_enable(o1[6]), .read(o1[5]),
    .write(o1[4]), .MDR_out(o1[3]), .busy(o1[2]), .done(o1[1]), .addr_err(o1[0])
  );
  mem_access_ctrl #(.WAIT_CYCLES(3)) u3 (
    .clk(clk), .clr(clr), .start_load(start_load), .start_store(start_store),
    .bus_addr_hi(bus_addr_hi), .MAR_enable(o3[7]), .MDR_enable(o3[6]), .read(o3[5]),
    .write(o3[4]), .MDR_out(o3[3]), .busy(o3[2]), .done(o3[1]), .addr_err(o3[0])
  );
  typedef struct {
    logic ld;
    logic st;
    logic st2;
    logic [22:0] hi;
    int kind;
  } vec_t;
  vec_t vecs[10];
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask
  // bit order MAR MDR read write MDR_out busy done addr_err; kind 0 none 1 load 2 store 3 error
  function automatic logic [7:0] exp_out(input int kind, input int w, input int k);
    logic [7:0] e;
    e = '0;
    if (kind == 1) begin
      if (k == 1) e = 8'b1000_0100;
      else if (k >= 2 && k <= w + 1) e = 8'b0010_0100;
      else if (k == w + 2) e = 8'b0110_0100;
      else if (k == w + 3) e = 8'b0000_1110;
    end else if (kind == 2) begin
      if (k == 1) e = 8'b1000_0100;
      else if (k == 2) e = 8'b0100_0100;
      else if (k >= 3 && k <= w + 2) e = 8'b0001_0100;
      else if (k == w + 3) e = 8'b0000_0110;
    end else if (kind == 3) begin
      if (k == 1) e = 8'b0000_0101;
    end
    return e;
  endfunction
  task automatic run_vec(input vec_t v, input int ncyc);
    @(negedge clk);
    start_load = v.ld;
    start_store = v.st;
    bus_addr_hi = v.hi;
    @(negedge clk);
    start_load = 1'b0;
    start_store = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      if (k > 1) @(negedge clk);
      check($sformatf("w1 kind%0d cyc%0d", v.kind, k), o1, exp_out(v.kind, 1, k));
      check($sformatf("w3 kind%0d cyc%0d", v.kind, k), o3, exp_out(v.kind, 3, k));
      start_store = (k == 2 && v.st2);
    end
    start_store = 1'b0;
    bus_addr_hi = '0;
  endtask
  initial begin
    int rem1, rem3, acc1, acc3, er1, er3, dn1, dn3, ae1, ae3;
    logic ld, st;
    logic [22:0] hi;
    vecs[0] = '{1'b1, 1'b0, 1'b0, 23'h0, 1};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 23'h0, 2};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 23'h1, 3};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 23'h400000, 3};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 23'h0, 1};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 23'h100, 3};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 23'h0, 0};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 23'h0, 2};
    vecs[8] = '{1'b1, 1'b0, 1'b0, 23'h0, 1};
    vecs[9] = '{1'b0, 1'b0, 1'b0, 23'h7fffff, 0};
    repeat (2) @(posedge clk);
    #1;
    check("reset w1", o1, 8'h00);
    check("reset w3", o3, 8'h00);
    @(negedge clk);
    clr = 1'b0;
    foreach (vecs[i]) run_vec(vecs[i], 8);
    // clear arrives in cycle 4 of a store while both instances are active
    @(negedge clk);
    start_store = 1'b1;
    @(negedge clk);
    start_store = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) @(negedge clk);
      check($sformatf("pre-clr w3 cyc%0d", k), o3, exp_out(2, 3, k));
    end
    #2 clr = 1'b1;
    #1;
    check("async clr w1", o1, 8'h00);
    check("async clr w3", o3, 8'h00);
    @(negedge clk);
    check("held clr w3", o3, 8'h00);
    clr = 1'b0;
    run_vec(vecs[0], 8);
    rem1 = 0; rem3 = 0; acc1 = 0; acc3 = 0; er1 = 0; er3 = 0;
    dn1 = 0; dn3 = 0; ae1 = 0; ae3 = 0;
    for (int i = 0; i < 1030; i++) begin
      @(negedge clk);
      check($sformatf("rand busy/inv w1 i%0d", i),
            {o1[2], o1[5] & o1[4], o1[4] & o1[6], o1[1] & o1[0]}, {rem1 > 0, 3'b000});
      check($sformatf("rand busy/inv w3 i%0d", i),
            {o3[2], o3[5] & o3[4], o3[4] & o3[6], o3[1] & o3[0]}, {rem3 > 0, 3'b000});
      dn1 += int'(o1[1]); dn3 += int'(o3[1]);
      ae1 += int'(o1[0]); ae3 += int'(o3[0]);
      ld = (i < 1000) && ($urandom_range(0, 2) == 0);
      st = (i < 1000) && ($urandom_range(0, 2) == 0);
      hi = ($urandom_range(0, 7) == 0) ? (23'h1 << $urandom_range(0, 22)) : 23'h0;
      start_load = ld;
      start_store = st;
      bus_addr_hi = hi;
      if (rem1 == 0 && (ld || st)) begin
        if (hi != 0) begin rem1 = 1; er1++; end else begin rem1 = 4; acc1++; end
      end else if (rem1 > 0) rem1--;
      if (rem3 == 0 && (ld || st)) begin
        if (hi != 0) begin rem3 = 1; er3++; end else begin rem3 = 6; acc3++; end
      end else if (rem3 > 0) rem3--;
    end
    start_load = 1'b0;
    start_store = 1'b0;
    bus_addr_hi = '0;
    checks++;
    if (dn1 != acc1) begin errors++; $display("FAIL rand done w1: got %0d expected %0d", dn1, acc1); end
    checks++;
    if (dn3 != acc3) begin errors++; $display("FAIL rand done w3: got %0d expected %0d", dn3, acc3); end
    checks++;
    if (ae1 != er1) begin errors++; $display("FAIL rand addr_err w1: got %0d expected %0d", ae1, er1); end
    checks++;
    if (ae3 != er3) begin errors++; $display("FAIL rand addr_err w3: got %0d expected %0d", ae3, er3); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequencer directly upstream of the memory datapath (MAR, MDR, 512x32 RAM).
- Turns single-cycle load/store requests from the CPU control unit into the ordered MAR_enable / MDR_enable / read / write strobe sequence.
- Inserts a configurable number of RAM wait cycles, flags addresses outside the 9-bit RAM space, and tells the control unit when the transfer is complete.

Parameters:
- WAIT_CYCLES, 1, RAM access cycles that read/write is held before data is latched or the write completes; legal range 1..15.
- ADDR_W, 9, RAM address width; matches the MAR width.

Ports:
- clk  input  1  system clock, rising edge
- clr  input  1  asynchronous, active-high reset
- start_load  input  1  one-cycle load request from the control unit
- start_store  input  1  one-cycle store request from the control unit
- bus_addr_hi  input  23  bus bits [31:9] at request time; any nonzero bit is an address error
- MAR_enable  output  1  MAR load strobe to the memory datapath
- MDR_enable  output  1  MDR load strobe to the memory datapath
- read  output  1  RAM read / MDR source select
- write  output  1  RAM write strobe
- MDR_out  output  1  tells the control unit to gate MDR_Data onto the bus
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle completion pulse
- addr_err  output  1  one-cycle pulse for a rejected request

Behaviour:
- All outputs are registered Moore decodes of state. No combinational path runs from any input to any output.
- Reset:
  - clr high forces state IDLE, wait counter 0 and every output 0 immediately, regardless of clk.
  - This holds mid-transfer. A partially completed store leaves RAM contents unspecified for that address only.
- States: IDLE, ADDR, RD_WAIT, RD_LATCH, ST_DATA, WR_WAIT, DONE, ERR.
- IDLE:
  - start_load=1: if bus_addr_hi != 0, go to ERR; else latch op=load and go to ADDR.
  - start_store=1 (and start_load=0): same check, with op=store.
  - Both starts in the same cycle: load wins and the store is dropped, not queued.
- ERR: addr_err=1 for one cycle, then IDLE. done stays 0 and no memory strobes are issued.
- ADDR: MAR_enable=1 for one cycle. The control unit holds the address on the bus through this cycle. Next state is RD_WAIT for a load, ST_DATA for a store.
- RD_WAIT:
  - read=1 for exactly WAIT_CYCLES cycles.
  - The counter is loaded with WAIT_CYCLES-1 on entry and decremented each cycle; exit to RD_LATCH when it reads 0.
- RD_LATCH: read=1, MDR_enable=1 for one cycle, then DONE.
- ST_DATA: MDR_enable=1, read=0 for one cycle (MDR takes bus data). The control unit holds the store data on the bus during this cycle. Next state is WR_WAIT.
- WR_WAIT: write=1 for exactly WAIT_CYCLES cycles, same counter rule as RD_WAIT, then DONE.
- DONE:
  - done=1 for one cycle.
  - MDR_out=1 as well, for a load only.
  - Then IDLE.
- Latency: with the request sampled at edge 0, done is high in cycle WAIT_CYCLES+3 for both load and store. The next request is accepted in the cycle after DONE.
- start_load and start_store are ignored whenever busy=1.
- Invariants: read and write are never both 1; write=1 never coincides with MDR_enable=1; at most one of done and addr_err is high.
- The counter is 4 bits. WAIT_CYCLES outside 1..15 is a compile-time error.

Decomposition:
- Shared package mem_ctrl_pkg holds:
  - state encoding localparams (binary, 3 bits)
  - ADDR_W=9 and DATA_W=32
  - the wait-counter width constant
- No sub-module; the wait counter is inline. The block is a single FSM of roughly 150-200 lines.

Test Plan:
- Reset, then start_load with bus_addr_hi=0 and WAIT_CYCLES=1 -> MAR_enable in cycle 1, read in cycles 2-3, MDR_enable in cycle 3, done and MDR_out in cycle 4, busy in cycles 1-4.
- start_store with WAIT_CYCLES=3 -> MAR_enable in cycle 1, MDR_enable in cycle 2, write in cycles 3-5, done in cycle 6; read stays 0 throughout. Paired with memory_datapath, a following load of the same address returns 0xDEADBEEF.
- start_load with bus_addr_hi=23'h1 -> addr_err pulse in cycle 1, no strobes, done stays 0, busy high for exactly 1 cycle.
- start_load and start_store in the same cycle, plus start_store pulsed at cycle 2 -> a single load sequence runs, no write ever asserts, exactly one done.
- Assert clr during cycle 4 of a WAIT_CYCLES=3 store -> all outputs 0 before the next clk edge. A start_load issued after clr is released completes normally in 6 cycles.
- Random back-to-back loads and stores for 1000 cycles -> invariants hold, and the done count equals the count of accepted requests.
